// File: rtl/alu_multicycle.sv
// Handshaked data-processing ALU with NZCV flags, plus an iterative MUL/MLA unit.
// One-entry registered result held until the consumer accepts it.
module alu_multicycle #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       codein,
  input  logic             mul,
  input  logic             acc,
  input  logic [WIDTH-1:0] Rn,
  input  logic [WIDTH-1:0] shifter,
  input  logic [WIDTH-1:0] Ra,
  input  logic             carry_in,
  input  logic             shifter_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flagsout,
  output logic [3:0]       flagsenable
);

  localparam int unsigned N_ITER = WIDTH / MUL_BITS;
  localparam int unsigned CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } alu_op_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_out;
  logic [3:0]       r_flags;
  logic [3:0]       r_fen;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_last;
  alu_op_t          w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic             w_arith;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_dp_res;
  logic [3:0]       w_dp_flags;
  logic [3:0]       w_dp_fen;
  logic [WIDTH-1:0] w_pp;
  logic [WIDTH-1:0] w_mul_res;
  logic [3:0]       w_mul_flags;

  assign in_ready    = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_last      = (r_state == S_MUL) && (r_cnt == CW'(N_ITER - 1));
  assign w_op        = alu_op_t'(codein);

  assign out_valid   = r_out_valid;
  assign out         = r_out;
  assign flagsout    = r_flags;
  assign flagsenable = r_fen;

  // Adder operand selection: subtracts invert one operand, carry-in supplies the +1 or CPSR C.
  always_comb begin
    w_a     = Rn;
    w_b     = shifter;
    w_cin   = 1'b0;
    w_arith = 1'b0;
    case (w_op)
      OP_SUB, OP_CMP: begin w_b = ~shifter; w_cin = 1'b1; w_arith = 1'b1; end
      OP_RSB:         begin w_a = shifter; w_b = ~Rn; w_cin = 1'b1; w_arith = 1'b1; end
      OP_ADD, OP_CMN: begin w_arith = 1'b1; end
      OP_ADC:         begin w_cin = carry_in; w_arith = 1'b1; end
      OP_SBC:         begin w_b = ~shifter; w_cin = carry_in; w_arith = 1'b1; end
      OP_RSC:         begin w_a = shifter; w_b = ~Rn; w_cin = carry_in; w_arith = 1'b1; end
      default:        ;
    endcase
  end

  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};

  always_comb begin
    w_dp_res = w_sum[WIDTH-1:0];
    case (w_op)
      OP_AND, OP_TST: w_dp_res = Rn & shifter;
      OP_EOR, OP_TEQ: w_dp_res = Rn ^ shifter;
      OP_ORR:         w_dp_res = Rn | shifter;
      OP_MOV:         w_dp_res = shifter;
      OP_BIC:         w_dp_res = Rn & ~shifter;
      OP_MVN:         w_dp_res = ~shifter;
      default:        ;
    endcase
  end

  always_comb begin
    w_dp_flags    = '0;
    w_dp_flags[0] = (w_dp_res == '0);
    w_dp_flags[2] = w_dp_res[WIDTH-1];
    if (w_arith) begin
      w_dp_flags[1] = w_sum[WIDTH];
      w_dp_flags[3] = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      w_dp_fen      = 4'b1111;
    end else begin
      w_dp_flags[1] = shifter_carry;
      w_dp_fen      = 4'b0111;
    end
  end

  // Partial product of the multiplicand with the low MUL_BITS multiplier bits.
  always_comb begin
    w_pp = '0;
    for (int unsigned j = 0; j < MUL_BITS; j++) begin
      if (r_mplier[j]) begin
        w_pp = w_pp + (r_mcand << j);
      end
    end
  end

  assign w_mul_res   = r_acc + w_pp;
  assign w_mul_flags = {1'b0, w_mul_res[WIDTH-1], 1'b0, (w_mul_res == '0)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && mul) w_state_next = S_MUL;
      S_MUL:   if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (w_accept && mul) begin
      r_cnt    <= '0;
      r_mcand  <= Rn;
      r_mplier <= shifter;
      r_acc    <= acc ? Ra : '0;
    end else if (r_state == S_MUL) begin
      r_cnt    <= r_cnt + CW'(1);
      r_mcand  <= r_mcand << MUL_BITS;
      r_mplier <= r_mplier >> MUL_BITS;
      r_acc    <= w_mul_res;
    end
  end

  // A multiply only starts when the result slot drains, so the slot is free on its last iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out       <= '0;
      r_flags     <= '0;
      r_fen       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept && !mul) begin
      r_out       <= w_dp_res;
      r_flags     <= w_dp_flags;
      r_fen       <= w_dp_fen;
      r_out_valid <= 1'b1;
    end else if (w_last) begin
      r_out       <= w_mul_res;
      r_flags     <= w_mul_flags;
      r_fen       <= 4'b0101;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: data-processing vectors, MUL/MLA latency
// for two MUL_BITS settings, reset mid-multiply and output backpressure.
module tb_alu_multicycle;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_valid4, mul, acc, carry_in, shifter_carry;
  logic         out_ready, out_ready4;
  logic [3:0]   codein;
  logic [W-1:0] Rn, shifter, Ra;
  logic         in_ready, out_valid, in_ready4, out_valid4;
  logic [W-1:0] out, out4;
  logic [3:0]   flagsout, flagsenable, flagsout4, flagsenable4;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W), .MUL_BITS(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .codein(codein), .mul(mul), .acc(acc), .Rn(Rn), .shifter(shifter), .Ra(Ra),
    .carry_in(carry_in), .shifter_carry(shifter_carry), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .flagsout(flagsout), .flagsenable(flagsenable)
  );

  alu_multicycle #(.WIDTH(W), .MUL_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .codein(codein), .mul(mul), .acc(acc), .Rn(Rn), .shifter(shifter), .Ra(Ra),
    .carry_in(carry_in), .shifter_carry(shifter_carry), .out_valid(out_valid4),
    .out_ready(out_ready4), .out(out4), .flagsout(flagsout4), .flagsenable(flagsenable4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts cycles from the accept edge (1) until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] rn;
    logic [W-1:0] sh;
    logic         cin;
    logic         shc;
    logic [W-1:0] res;
    logic [3:0]   fl;
    logic [3:0]   en;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, lat1, lat4, cyc;
    logic [W-1:0] o1, o4;
    logic [3:0]   f1, f4, e1, e4;

    // flags order {V,N,C,Z}
    vecs = '{
      '{4'h4, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 4'b1100, 4'b1111},
      '{4'h2, 32'h00000005, 32'h00000005, 1'b0, 1'b0, 32'h00000000, 4'b0011, 4'b1111},
      '{4'h6, 32'h00000005, 32'h00000005, 1'b0, 1'b0, 32'hFFFFFFFF, 4'b0100, 4'b1111},
      '{4'h7, 32'h00000001, 32'h00000003, 1'b1, 1'b0, 32'h00000002, 4'b0010, 4'b1111},
      '{4'h0, 32'h0000F0F0, 32'h00000FF0, 1'b0, 1'b1, 32'h000000F0, 4'b0010, 4'b0111},
      '{4'h1, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 1'b0, 32'hF00FF00F, 4'b0100, 4'b0111},
      '{4'h3, 32'h0000000A, 32'h00000003, 1'b0, 1'b0, 32'hFFFFFFF9, 4'b0100, 4'b1111},
      '{4'h5, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 4'b0011, 4'b1111},
      '{4'hA, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 32'h7FFFFFFF, 4'b1010, 4'b1111},
      '{4'hB, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 4'b0011, 4'b1111},
      '{4'hC, 32'h12340000, 32'h00005678, 1'b1, 1'b0, 32'h12345678, 4'b0000, 4'b0111},
      '{4'hD, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 4'b0011, 4'b0111},
      '{4'hE, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 1'b0, 32'hFFFF0000, 4'b0100, 4'b0111},
      '{4'hF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 4'b0001, 4'b0111},
      '{4'h8, 32'h0000000A, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 4'b0011, 4'b0111},
      '{4'h9, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 32'h80000000, 4'b0100, 4'b0111}
    };

    reset = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; mul = 1'b0; acc = 1'b0;
    carry_in = 1'b0; shifter_carry = 1'b0; out_ready = 1'b1; out_ready4 = 1'b1;
    codein = 4'h0; Rn = '0; shifter = '0; Ra = '0;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_out", out, 32'h0);
    check("rst_flags", flagsout, 4'h0);
    check("rst_fen", flagsenable, 4'h0);
    check("rst_valid4", out_valid4, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back data-processing ops, one result per cycle
    foreach (vecs[i]) begin
      codein = vecs[i].op; Rn = vecs[i].rn; shifter = vecs[i].sh;
      carry_in = vecs[i].cin; shifter_carry = vecs[i].shc; in_valid = 1'b1;
      check($sformatf("dp%0d_ready", i), in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("dp%0d_valid", i), out_valid, 1'b1);
      check($sformatf("dp%0d_out", i), out, vecs[i].res);
      check($sformatf("dp%0d_flags", i), flagsout, vecs[i].fl);
      check($sformatf("dp%0d_fen", i), flagsenable, vecs[i].en);
    end
    @(posedge clk); #1;
    check("dp_drain", out_valid, 1'b0);

    // MUL with operands changed after accept; acc=0 so Ra is ignored
    mul = 1'b1; acc = 1'b0; Rn = 32'd7; shifter = 32'd6; Ra = 32'd100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; Rn = 32'h1234; shifter = 32'h5678; Ra = 32'h55;
    check("mul_busy_ready", in_ready, 1'b0);
    wait_valid(lat);
    check("mul_lat", lat, 33);
    check("mul_out", out, 32'd42);
    check("mul_flags", flagsout, 4'b0000);
    check("mul_fen", flagsenable, 4'b0101);

    // MLA on both instances, accepted on the same edge
    acc = 1'b1; Rn = 32'h0000FFFF; shifter = 32'h00010001; Ra = 32'd3;
    in_valid = 1'b1; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid4 = 1'b0;
    lat1 = 0; lat4 = 0; o1 = '0; o4 = '0; f1 = '0; f4 = '0; e1 = '0; e4 = '0;
    cyc = 1;
    while (cyc <= 100 && (lat1 == 0 || lat4 == 0)) begin
      if (lat1 == 0 && out_valid) begin
        lat1 = cyc; o1 = out; f1 = flagsout; e1 = flagsenable;
      end
      if (lat4 == 0 && out_valid4) begin
        lat4 = cyc; o4 = out4; f4 = flagsout4; e4 = flagsenable4;
      end
      if (lat1 == 0 || lat4 == 0) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("mla1_lat", lat1, 33);
    check("mla1_out", o1, 32'h00000002);
    check("mla1_flags", f1, 4'b0000);
    check("mla1_fen", e1, 4'b0101);
    check("mla4_lat", lat4, 9);
    check("mla4_out", o4, 32'h00000002);
    check("mla4_flags", f4, 4'b0000);
    check("mla4_fen", e4, 4'b0101);

    // Reset five cycles into a multiply
    @(posedge clk); #1;
    acc = 1'b0; Rn = 32'd3; shifter = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rstmul_valid", out_valid, 1'b0);
    check("rstmul_out", out, 32'h0);
    check("rstmul_fen", flagsenable, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("postrst_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("postrst_lat", lat, 33);
    check("postrst_out", out, 32'd15);
    @(posedge clk); #1;

    // Backpressure: ADD held while a SUB waits, then issued as the ADD drains
    mul = 1'b0; out_ready = 1'b0;
    codein = 4'h4; Rn = 32'd1; shifter = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    codein = 4'h2; Rn = 32'd10; shifter = 32'd4;
    check("bp_add_out", out, 32'd3);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_ready", k), in_ready, 1'b0);
      check($sformatf("bp%0d_valid", k), out_valid, 1'b1);
      check($sformatf("bp%0d_out", k), out, 32'd3);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1'b1);
    check("bp_next_out", out, 32'd6);
    check("bp_next_flags", flagsout, 4'b0010);
    @(posedge clk); #1;
    check("bp_drain", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
